// File: rtl/core_launch_ctrl.sv
// Launch controller for a compute core: holds core reset, runs the kernel and reports completion.
// Optional `WATCHDOG_EN bounds RUN to WDT_LIMIT cycles; state_o exposes the FSM state for debug.
module core_launch_ctrl #(
   parameter int unsigned RST_CYCLES = 4,
   parameter int unsigned CNT_WIDTH  = 32,
   parameter int unsigned WDT_LIMIT  = 1000000
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic                 clear_i,
   input  logic                 core_done_i,
   output logic                 core_clk_en_o,
   output logic                 core_rst_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 irq_o,
   output logic [1:0]           status_o,
   output logic [CNT_WIDTH-1:0] cycle_cnt_o,
   output logic [1:0]           state_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RST  = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [1:0] ST_NONE  = 2'b00;
   localparam logic [1:0] ST_OK    = 2'b01;
   localparam logic [1:0] ST_ABORT = 2'b10;
   localparam logic [1:0] ST_TMO   = 2'b11;

   state_t     r_state;
   state_t     w_nxt;
   logic [7:0] r_rst_cnt;
   logic       w_timeout;
   logic       w_cnt_max;

   assign w_cnt_max = &cycle_cnt_o;
   assign state_o   = r_state;

`ifdef WATCHDOG_EN
   assign w_timeout = (r_state == S_RUN) && (cycle_cnt_o == CNT_WIDTH'(WDT_LIMIT));
`else
   // Constant false: the limit is referenced only to keep the parameter in the interface.
   assign w_timeout = (WDT_LIMIT == 0) && 1'b0;
`endif

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE: if (start_i) w_nxt = S_RST;
         S_RST: begin
            if (abort_i)                w_nxt = S_DONE;
            else if (r_rst_cnt == 8'd1) w_nxt = S_RUN;
         end
         S_RUN:  if (abort_i || core_done_i || w_timeout) w_nxt = S_DONE;
         S_DONE: begin
            if (start_i)      w_nxt = S_RST;
            else if (clear_i) w_nxt = S_IDLE;
         end
         default: w_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered by decoding the state being entered on this edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state       <= S_IDLE;
         r_rst_cnt     <= 8'd0;
         core_clk_en_o <= 1'b0;
         core_rst_o    <= 1'b1;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         irq_o         <= 1'b0;
         status_o      <= ST_NONE;
         cycle_cnt_o   <= '0;
      end else begin
         r_state       <= w_nxt;
         core_clk_en_o <= (w_nxt == S_RST) || (w_nxt == S_RUN);
         core_rst_o    <= (w_nxt != S_RUN);
         busy_o        <= (w_nxt == S_RST) || (w_nxt == S_RUN);
         done_o        <= (w_nxt == S_DONE);
         irq_o         <= (w_nxt == S_DONE) && (r_state != S_DONE);
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_nxt == S_RST) begin
                  r_rst_cnt   <= 8'(RST_CYCLES);
                  cycle_cnt_o <= '0;
                  status_o    <= ST_NONE;
               end
            end
            S_RST: begin
               if (abort_i) status_o  <= ST_ABORT;
               else         r_rst_cnt <= r_rst_cnt - 8'd1;
            end
            S_RUN: begin
               // The cycle that sees done or abort is still counted; a timeout freezes at the limit.
               if (!w_cnt_max && (abort_i || core_done_i || !w_timeout))
                  cycle_cnt_o <= cycle_cnt_o + 1'b1;
               if (abort_i)          status_o <= ST_ABORT;
               else if (core_done_i) status_o <= ST_OK;
               else if (w_timeout)   status_o <= ST_TMO;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_core_launch_ctrl.sv
// Bench for core_launch_ctrl: vector table through a scoreboard queue, plus long-run sequences
// for the watchdog / unbounded RUN and a 4-bit instance for counter saturation.
module tb_core_launch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        clear = 1'b0;
   logic        core_done = 1'b0;

   logic        clk_en, core_rst, busy, done, irq;
   logic [1:0]  status, state;
   logic [31:0] cnt;

   logic        s_clk_en, s_core_rst, s_busy, s_done, s_irq;
   logic [1:0]  s_status, s_state;
   logic [3:0]  s_cnt;

   int n_checks = 0;
   int n_errors = 0;

   logic [40:0] exp_q[$];

   typedef struct {
      string       name;
      logic        r, s, a, c, d;
      int          reps;
      logic [40:0] exp;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   core_launch_ctrl #(.RST_CYCLES(4), .CNT_WIDTH(32), .WDT_LIMIT(20)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .clear_i(clear),
      .core_done_i(core_done), .core_clk_en_o(clk_en), .core_rst_o(core_rst),
      .busy_o(busy), .done_o(done), .irq_o(irq), .status_o(status),
      .cycle_cnt_o(cnt), .state_o(state)
   );

   core_launch_ctrl #(.RST_CYCLES(4), .CNT_WIDTH(4), .WDT_LIMIT(15)) dut_sat (
      .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .clear_i(clear),
      .core_done_i(core_done), .core_clk_en_o(s_clk_en), .core_rst_o(s_core_rst),
      .busy_o(s_busy), .done_o(s_done), .irq_o(s_irq), .status_o(s_status),
      .cycle_cnt_o(s_cnt), .state_o(s_state)
   );

   function automatic logic [40:0] expv(logic en, logic cr, logic b, logic d, logic i,
                                        logic [1:0] st, logic [31:0] c);
      logic [1:0] dbg;
      dbg = b ? (cr ? 2'd1 : 2'd2) : (d ? 2'd3 : 2'd0);
      return {en, cr, b, d, i, st, c, dbg};
   endfunction

   function automatic logic [40:0] e_idle(logic [1:0] st, logic [31:0] c);
      return expv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, st, c);
   endfunction

   function automatic logic [40:0] e_rst();
      return expv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 32'd0);
   endfunction

   function automatic logic [40:0] e_run(logic [31:0] c);
      return expv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, c);
   endfunction

   function automatic logic [40:0] e_done(logic [1:0] st, logic [31:0] c, logic i);
      return expv(1'b0, 1'b1, 1'b0, 1'b1, i, st, c);
   endfunction

   task automatic check(input string name, input logic [40:0] act, input logic [40:0] expd);
      n_checks++;
      if (act !== expd) begin
         n_errors++;
         $display("FAIL %s: got {en,rst,busy,done,irq,st,cnt,state}=%h required %h", name, act, expd);
      end
   endtask

   task automatic add(input string name, input logic r, input logic s, input logic a,
                      input logic c, input logic d, input int reps, input logic [40:0] expd);
      tbl.push_back('{name, r, s, a, c, d, reps, expd});
   endtask

   // Drive the inputs for reps cycles; the expected outputs after the last edge go through exp_q.
   task automatic step(input string name, input logic r, input logic s, input logic a,
                       input logic c, input logic d, input int reps, input logic [40:0] expd);
      logic [40:0] e;
      for (int k = 0; k < reps; k++) begin
         rst = r; start = s; abort = a; clear = c; core_done = d;
         if (k == reps - 1) exp_q.push_back(expd);
         @(posedge clk);
         #1;
      end
      rst = 1'b0; start = 1'b0; abort = 1'b0; clear = 1'b0; core_done = 1'b0;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = exp_q.pop_front();
         check(name, {clk_en, core_rst, busy, done, irq, status, cnt, state}, e);
      end
   endtask

   initial begin
      add("reset",             1, 0, 0, 0, 0, 3,  e_idle(2'b00, 0));
      add("idle",              0, 0, 0, 0, 0, 2,  e_idle(2'b00, 0));
      add("start",             0, 1, 0, 0, 0, 1,  e_rst());
      add("rst_ignores_done",  0, 0, 0, 0, 1, 3,  e_rst());
      add("rst_to_run",        0, 1, 0, 0, 0, 1,  e_run(0));
      add("run_count",         0, 0, 0, 0, 0, 14, e_run(14));
      add("run_start_ignored", 0, 1, 0, 0, 0, 1,  e_run(15));
      add("done_ok",           0, 0, 0, 0, 1, 1,  e_done(2'b01, 16, 1'b1));
      add("done_hold",         0, 0, 0, 0, 0, 1,  e_done(2'b01, 16, 1'b0));
      add("clear",             0, 0, 0, 1, 0, 1,  e_idle(2'b01, 16));
      add("idle_abort_clear",  0, 0, 1, 1, 0, 2,  e_idle(2'b01, 16));
      add("restart",           0, 1, 0, 0, 0, 1,  e_rst());
      add("abort_in_rst",      0, 0, 1, 0, 0, 1,  e_done(2'b10, 0, 1'b1));
      add("start_over_clear",  0, 1, 0, 1, 0, 1,  e_rst());
      add("to_run",            0, 0, 0, 0, 0, 4,  e_run(0));
      add("run5",              0, 0, 0, 0, 0, 5,  e_run(5));
      add("abort_and_done",    0, 0, 1, 0, 1, 1,  e_done(2'b10, 6, 1'b1));
      add("after_abort",       0, 0, 0, 0, 0, 1,  e_done(2'b10, 6, 1'b0));
      add("start_from_done",   0, 1, 0, 0, 0, 1,  e_rst());
      add("to_run2",           0, 0, 0, 0, 0, 4,  e_run(0));
      add("run7",              0, 0, 0, 0, 0, 7,  e_run(7));
      add("mid_run_reset",     1, 1, 0, 0, 0, 1,  e_idle(2'b00, 0));
      add("idle_after_reset",  0, 0, 0, 0, 0, 1,  e_idle(2'b00, 0));
      add("start_under_reset", 1, 1, 0, 0, 0, 2,  e_idle(2'b00, 0));

      foreach (tbl[i])
         step(tbl[i].name, tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].c, tbl[i].d, tbl[i].reps, tbl[i].exp);

      // Long launch with no done: saturation on the 4-bit instance, then watchdog or unbounded RUN.
      step("ls_start",  0, 1, 0, 0, 0, 1,  e_rst());
      step("ls_to_run", 0, 0, 0, 0, 0, 4,  e_run(0));
      step("ls_run20",  0, 0, 0, 0, 0, 20, e_run(20));
      check("sat_cnt", {37'd0, s_cnt}, {37'd0, 4'd15});
`ifdef WATCHDOG_EN
      step("wdt_timeout", 0, 0, 0, 0, 0, 1, e_done(2'b11, 20, 1'b1));
      step("wdt_hold",    0, 0, 0, 0, 0, 1, e_done(2'b11, 20, 1'b0));
      step("wdt_clear",   0, 0, 0, 1, 0, 1, e_idle(2'b11, 20));
`else
      step("no_wdt",      0, 0, 0, 0, 0, 1,   e_run(21));
      step("run1000",     0, 0, 0, 0, 0, 979, e_run(1000));
      check("sat_cnt_long", {37'd0, s_cnt}, {37'd0, 4'd15});
      step("end_abort",   0, 0, 1, 0, 0, 1,   e_done(2'b10, 1001, 1'b1));
      step("end_clear",   0, 0, 0, 1, 0, 1,   e_idle(2'b10, 1001));
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
